ifx_dig_data_bus_driver: RTL and testbench
==========================================

Name: ifx_dig_data_bus_driver

Overview:
Parametrised multi-channel successor to the single-width data bus interface. It accepts queued drive requests (channel, value, hold time) over a valid/ready handshake and buffers them in a FIFO. It applies each request to its channel's slice of a registered output bus for the requested number of cycles. It sits between sequence/stimulus logic and the DUT data pins, and also drives digital data buses in emulation tops.

Parameters:
DWIDTH, 8, bits per channel
NUM_CH, 4, number of output channels (>=1)
DEPTH, 4, request FIFO entries (power of 2, >=2)
HWIDTH, 8, width of hold-cycle count
RESET_VAL, '0, per-channel data value after reset

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  FIFO can accept (= !full)
req_ch_i  input  CHW  target channel, CHW = max(1,$clog2(NUM_CH))
req_data_i  input  DWIDTH  value to drive
req_hold_i  input  HWIDTH  hold cycles (0 treated as 1)
flush_i  input  1  synchronous flush of queue and current hold
data_o  output  NUM_CH*DWIDTH  driven bus, channel c at [c*DWIDTH +: DWIDTH]
active_ch_o  output  CHW  channel of current request
busy_o  output  1  FSM in DRIVE
done_o  output  1  one-cycle pulse at end of a hold
err_o  output  1  one-cycle pulse on popped out-of-range channel
level_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): every channel of data_o = RESET_VAL; FIFO empty; level_o=0; FSM IDLE; busy_o, done_o, err_o, active_ch_o = 0.
- Push occurs when req_valid_i && req_ready_o. req_ready_o = (level_o != DEPTH). No push into a full FIFO, even with a same-cycle pop.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head entry.
  - Valid channel: load data_o slice for that channel and set cnt = max(hold,1)-1; go to DRIVE.
  - Invalid channel (>= NUM_CH): drop the entry, pulse err_o, stay IDLE.
  - DRIVE: if cnt != 0, decrement cnt.
  - DRIVE, cnt == 0: pulse done_o. If FIFO is non-empty, pop and load the next entry in the same edge (back-to-back, no idle cycle). Otherwise go to IDLE.
  - Back-to-back pop of an invalid channel: err_o pulses together with done_o, and the FSM goes to IDLE.
- Latency: a request accepted at edge k into an empty FIFO with FSM IDLE appears on data_o at edge k+1. A request with hold h occupies exactly h cycles of DRIVE.
- Untargeted channels retain their last value indefinitely. data_o is never cleared except by reset.
- Simultaneous push and pop (non-full): both occur and level_o is unchanged.
- FIFO pointers wrap modulo DEPTH.
- flush_i has priority over push and pop in its cycle. Next edge: FIFO empty, cnt=0, FSM IDLE, busy_o=0. No done_o pulse. data_o is held.
- active_ch_o updates on each load and holds its value in IDLE.
- Reset asserted mid-hold: immediate return to reset state. The queue is lost.

Optional Feature:
Macro IFX_DIG_DATA_BUS_PARITY_EN.
- Defined: adds output parity_o [NUM_CH-1:0]. parity_o[c] is the registered even parity (XOR) of channel c's data_o slice. It updates on the same edge as data_o, and its reset value is the parity of RESET_VAL.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ifx_dig_data_bus_pkg holds:
  - the state enum (IDLE, DRIVE);
  - a localparam function for CHW;
  - default parameter constants.
- A request packing order constant {ch, hold, data} is shared with the bench.
- Sub-module ifx_dig_data_bus_fifo:
  - parametrised width/depth synchronous FIFO, async active-low reset;
  - outputs full, empty and level;
  - synchronous flush input.

Test Plan:
- Reset then idle: data_o = {4{8'h00}}, level_o=0, req_ready_o=1, busy_o=0.
- Single request ch=2, data=8'hA5, hold=3:
  - data_o[23:16]=A5 one edge after acceptance;
  - busy_o high 3 cycles, done_o pulses on the last;
  - other channels unchanged.
- Fill 4 requests while driving a hold=10 entry:
  - 5th push stalls with req_ready_o=0, level_o=4;
  - entries then drain back-to-back with no idle gap, in order.
- hold=0 and hold=255 entries: occupy 1 and 255 DRIVE cycles respectively.
- NUM_CH=3 with req_ch_i=3: err_o pulses once on pop, data_o unchanged, next valid entry proceeds.
- flush_i mid-hold with 2 entries queued:
  - next cycle level_o=0, busy_o=0, no done_o;
  - data_o holds the last value.
- With parity: data 8'h07 gives parity_o bit = 1.

Source files
------------

// File: rtl/ifx_dig_data_bus_pkg.sv
// Shared definitions for the multi-channel data bus driver: FSM state type,
// channel-index width helper, default parameter values and the packing
// layout of a queued request word {ch, hold, data}.
package ifx_dig_data_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_HWIDTH = 8;

  // Channel index width; a single-channel bus still carries a 1-bit index.
  function automatic int chw_f(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Request word layout, MSB to LSB: {ch, hold, data}.
  function automatic int req_data_lsb();
    return 0;
  endfunction

  function automatic int req_hold_lsb(input int dwidth);
    return dwidth;
  endfunction

  function automatic int req_ch_lsb(input int dwidth, input int hwidth);
    return dwidth + hwidth;
  endfunction

  function automatic int req_width(input int dwidth, input int hwidth, input int chw);
    return dwidth + hwidth + chw;
  endfunction

endpackage

// File: rtl/ifx_dig_data_bus_fifo.sv
// Request FIFO for the data bus driver. Synchronous, power-of-two depth,
// asynchronous active-low reset, synchronous flush that wins over push/pop.
// The head entry is visible combinationally so the consumer can pop and use
// it on the same edge.
module ifx_dig_data_bus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_reg == LW'(DEPTH));
  assign empty_o = (level_reg == '0);
  assign level_o = level_reg;
  assign rdata_o = mem[rptr_reg];

  // A full FIFO never accepts, even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr_reg] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
    end else if (flush_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
    end else begin
      if (push_ok) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifx_dig_data_bus_driver.sv
// Multi-channel data bus driver. Queued requests {ch, hold, data} are applied
// to their channel's slice of a registered output bus for max(hold,1) cycles,
// back-to-back when the queue is non-empty. Popped requests with an
// out-of-range channel are dropped with an error pulse.
// Optional: define IFX_DIG_DATA_BUS_PARITY_EN to add per-channel registered
// even parity output parity_o.
module ifx_dig_data_bus_driver
  import ifx_dig_data_bus_pkg::*;
#(
  parameter int               DWIDTH    = DEF_DWIDTH,
  parameter int               NUM_CH    = DEF_NUM_CH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               HWIDTH    = DEF_HWIDTH,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0,
  localparam int              CHW       = chw_f(NUM_CH),
  localparam int              LW        = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [CHW-1:0]           req_ch_i,
  input  logic [DWIDTH-1:0]        req_data_i,
  input  logic [HWIDTH-1:0]        req_hold_i,
  input  logic                     flush_i,
  output logic [NUM_CH*DWIDTH-1:0] data_o,
  output logic [CHW-1:0]           active_ch_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [LW-1:0]            level_o
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
  ,
  output logic [NUM_CH-1:0]        parity_o
`endif
);

  localparam int RW       = req_width(DWIDTH, HWIDTH, CHW);
  localparam int DATA_LSB = req_data_lsb();
  localparam int HOLD_LSB = req_hold_lsb(DWIDTH);
  localparam int CH_LSB   = req_ch_lsb(DWIDTH, HWIDTH);

  logic [RW-1:0]     req_word;
  logic [RW-1:0]     head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     fifo_level;

  logic [DWIDTH-1:0] head_data;
  logic [HWIDTH-1:0] head_hold;
  logic [CHW-1:0]    head_ch;
  logic              head_ok;
  logic [HWIDTH-1:0] head_cnt;

  state_e            state_reg;
  logic [HWIDTH-1:0] cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [CHW-1:0]    active_ch_reg;

  logic              take;
  logic              pop;
  logic              load;

  assign req_word = {req_ch_i, req_hold_i, req_data_i};

  ifx_dig_data_bus_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (req_valid_i),
    .wdata_i (req_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign req_ready_o = !fifo_full;
  assign level_o     = fifo_level;

  assign head_data = head_word[DATA_LSB +: DWIDTH];
  assign head_hold = head_word[HOLD_LSB +: HWIDTH];
  assign head_ch   = head_word[CH_LSB +: CHW];
  assign head_ok   = ({1'b0, head_ch} < (CHW + 1)'(NUM_CH));

  // A hold of zero behaves as one cycle; the counter holds remaining-1.
  assign head_cnt = (head_hold == '0) ? '0 : head_hold - HWIDTH'(1);

  // The FSM is ready for a new entry when idle or in the last hold cycle.
  assign take = (state_reg == ST_IDLE) || (cnt_reg == '0);
  assign pop  = take && !fifo_empty && !flush_i;
  assign load = pop && head_ok;

  // Request sequencing: pop, load hold counter, count down, chain or idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      active_ch_reg <= '0;
    end else if (flush_i) begin
      // Abandon the current hold silently; bus values stay where they are.
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            if (head_ok) begin
              state_reg     <= ST_DRIVE;
              cnt_reg       <= head_cnt;
              busy_reg      <= 1'b1;
              active_ch_reg <= head_ch;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - HWIDTH'(1);
          end else begin
            done_reg <= 1'b1;
            if (pop && head_ok) begin
              cnt_reg       <= head_cnt;
              active_ch_reg <= head_ch;
            end else begin
              // Either nothing queued or the next entry is dropped.
              err_reg   <= pop;
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign active_ch_o = active_ch_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic              hit;
    logic [DWIDTH-1:0] data_reg;

    assign hit = load && (head_ch == CHW'(gi));

    // Channel slice register: takes a popped value aimed at it, else holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_reg <= RESET_VAL;
      end else if (hit) begin
        data_reg <= head_data;
      end
    end

    assign data_o[gi*DWIDTH +: DWIDTH] = data_reg;

`ifdef IFX_DIG_DATA_BUS_PARITY_EN
    logic parity_reg;

    // Parity tracks the slice register on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        parity_reg <= ^RESET_VAL;
      end else if (hit) begin
        parity_reg <= ^head_data;
      end
    end

    assign parity_o[gi] = parity_reg;
`endif
  end

endmodule

// File: tb/tb_ifx_dig_data_bus_driver.sv
// Bench for ifx_dig_data_bus_driver: queue-based reference model compared on
// every falling edge, plus directed literal checks. A second NUM_CH=3
// instance exercises out-of-range channels. Define
// IFX_DIG_DATA_BUS_PARITY_EN to also check parity_o.
module tb_ifx_dig_data_bus_driver;
  import ifx_dig_data_bus_pkg::*;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int DEP = 4;
  localparam int HW  = 8;
  localparam int CHW = chw_f(NCH);
  localparam int LW  = $clog2(DEP) + 1;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                req_valid_i;
  logic                req_ready_o;
  logic [CHW-1:0]      req_ch_i;
  logic [DW-1:0]       req_data_i;
  logic [HW-1:0]       req_hold_i;
  logic                flush_i;
  logic [NCH*DW-1:0]   data_o;
  logic [CHW-1:0]      active_ch_o;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [LW-1:0]       level_o;
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
  logic [NCH-1:0]      parity_o;
`endif

  // Second instance, three channels, for out-of-range requests.
  logic                b_valid;
  logic                b_ready;
  logic [1:0]          b_ch;
  logic [DW-1:0]       b_data_in;
  logic [HW-1:0]       b_hold;
  logic                b_flush;
  logic [3*DW-1:0]     b_data;
  logic [1:0]          b_active;
  logic                b_busy;
  logic                b_done;
  logic                b_err;
  logic [LW-1:0]       b_level;
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
  logic [2:0]          b_parity;
`endif

  int n_vec = 0;
  int n_err = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  always #5 clk_i = ~clk_i;

  ifx_dig_data_bus_driver #(
    .DWIDTH (DW), .NUM_CH (NCH), .DEPTH (DEP), .HWIDTH (HW)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_ch_i    (req_ch_i),
    .req_data_i  (req_data_i),
    .req_hold_i  (req_hold_i),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .active_ch_o (active_ch_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .level_o     (level_o)
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  ifx_dig_data_bus_driver #(
    .DWIDTH (DW), .NUM_CH (3), .DEPTH (DEP), .HWIDTH (HW)
  ) u_dut3 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (b_valid),
    .req_ready_o (b_ready),
    .req_ch_i    (b_ch),
    .req_data_i  (b_data_in),
    .req_hold_i  (b_hold),
    .flush_i     (b_flush),
    .data_o      (b_data),
    .active_ch_o (b_active),
    .busy_o      (b_busy),
    .done_o      (b_done),
    .err_o       (b_err),
    .level_o     (b_level)
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
    ,
    .parity_o    (b_parity)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          ch;
    logic [7:0]  data;
    int          hold;
  } req_t;

  req_t       mq[$];
  logic [7:0] m_data [NCH];
  int         m_rem;   // DRIVE cycles still to be shown, 0 when idle
  int         m_act;
  bit         m_done;
  bit         m_err;
  bit         m_push;
  req_t       m_e;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      for (int c = 0; c < NCH; c++) m_data[c] = 8'h00;
      m_rem = 0; m_act = 0; m_done = 0; m_err = 0;
    end else begin
      m_push = req_valid_i && (mq.size() != DEP);
      if (flush_i) begin
        mq.delete();
        m_rem = 0; m_done = 0; m_err = 0;
      end else begin
        m_done = (m_rem == 1);
        m_err  = 0;
        if (m_rem > 1) begin
          m_rem = m_rem - 1;
        end else begin
          m_rem = 0;
          if (mq.size() > 0) begin
            m_e = mq.pop_front();
            if (m_e.ch < NCH) begin
              m_data[m_e.ch] = m_e.data;
              m_rem = (m_e.hold == 0) ? 1 : m_e.hold;
              m_act = m_e.ch;
            end else begin
              m_err = 1;
            end
          end
        end
        if (m_push) mq.push_back('{int'(req_ch_i), req_data_i, int'(req_hold_i)});
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    logic [NCH*DW-1:0] exp_bus;
    for (int c = 0; c < NCH; c++) exp_bus[c*DW +: DW] = m_data[c];
    chk("data_o", data_o, exp_bus);
    chk("level_o", level_o, mq.size());
    chk("req_ready_o", req_ready_o, mq.size() != DEP);
    chk("busy_o", busy_o, m_rem > 0);
    chk("done_o", done_o, m_done);
    chk("err_o", err_o, m_err);
    chk("active_ch_o", active_ch_o, m_act);
`ifdef IFX_DIG_DATA_BUS_PARITY_EN
    for (int c = 0; c < NCH; c++) chk("parity_o", parity_o[c], ^m_data[c]);
`endif
    if (busy_o) busy_cycles++;
    if (done_o) done_pulses++;
  end

  // Present a request from a falling edge and hold it until accepted.
  task automatic push(input int ch, input logic [7:0] d, input int h);
    bit acc = 0;
    req_valid_i = 1'b1;
    req_ch_i    = CHW'(ch);
    req_data_i  = d;
    req_hold_i  = HW'(h);
    for (int i = 0; i < 2000; i++) begin
      if (req_ready_o) begin
        acc = 1;
        break;
      end
      @(negedge clk_i);
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    $display("push ch=%0d data=%h hold=%0d at %0t", ch, d, h, $time);
  endtask

  int b0, d0;

  initial begin
    req_valid_i = 0; req_ch_i = '0; req_data_i = '0; req_hold_i = '0; flush_i = 0;
    b_valid = 0; b_ch = '0; b_data_in = '0; b_hold = '0; b_flush = 0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_data", data_o, 32'h0000_0000);
    chk("rst_level", level_o, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single request: ch2 A5 hold 3
    b0 = busy_cycles; d0 = done_pulses;
    push(2, 8'hA5, 3);
    @(negedge clk_i);
    chk("single_load", data_o, 32'h00A5_0000);
    chk("single_act", active_ch_o, 2);
    repeat (6) @(negedge clk_i);
    chk("single_busy_cycles", busy_cycles - b0, 3);
    chk("single_done", done_pulses - d0, 1);
    chk("single_hold", data_o, 32'h00A5_0000);

    // Fill the queue while a long hold drives
    b0 = busy_cycles;
    push(0, 8'h11, 10);
    push(1, 8'h21, 1);
    push(2, 8'h32, 2);
    push(3, 8'h43, 0);
    push(0, 8'h54, 3);
    chk("fill_ready", req_ready_o, 0);
    chk("fill_level", level_o, 4);
    req_valid_i = 1'b1; req_ch_i = 2'd1; req_data_i = 8'h65; req_hold_i = 8'd2;
    @(negedge clk_i);
    chk("stall_ready", req_ready_o, 0);
    chk("stall_level", level_o, 4);
    push(1, 8'h65, 2);
    repeat (25) @(negedge clk_i);
    chk("drain_busy_cycles", busy_cycles - b0, 19);
    chk("drain_data", data_o, 32'h4332_6554);

    // Hold boundaries
    b0 = busy_cycles; d0 = done_pulses;
    push(1, 8'h42, 0);
    repeat (4) @(negedge clk_i);
    chk("hold0_cycles", busy_cycles - b0, 1);
    chk("hold0_done", done_pulses - d0, 1);
    b0 = busy_cycles; d0 = done_pulses;
    push(3, 8'hFF, 255);
    repeat (260) @(negedge clk_i);
    chk("hold255_cycles", busy_cycles - b0, 255);
    chk("hold255_done", done_pulses - d0, 1);
    chk("hold255_data", data_o, 32'hFF32_4254);

    // Flush mid-hold with two entries queued
    push(2, 8'h77, 20);
    push(0, 8'h01, 2);
    push(1, 8'h02, 2);
    repeat (3) @(negedge clk_i);
    d0 = done_pulses;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_level", level_o, 0);
    chk("flush_busy", busy_o, 0);
    chk("flush_done", done_o, 0);
    chk("flush_data", data_o, 32'hFF77_4254);
    chk("flush_act", active_ch_o, 2);
    repeat (5) @(negedge clk_i);
    chk("flush_no_done", done_pulses - d0, 0);

`ifdef IFX_DIG_DATA_BUS_PARITY_EN
    push(0, 8'h07, 1);
    @(negedge clk_i);
    chk("parity_07", parity_o[0], 1);
    repeat (3) @(negedge clk_i);
`endif

    // Out-of-range channel on the three-channel instance
    b_valid = 1; b_ch = 2'd3; b_data_in = 8'h55; b_hold = 8'd2;
    @(negedge clk_i);
    b_ch = 2'd1; b_data_in = 8'h3C; b_hold = 8'd1;
    @(negedge clk_i);
    b_valid = 0;
    chk("oor_err", b_err, 1);
    chk("oor_data", b_data, 24'h000000);
    chk("oor_busy", b_busy, 0);
    chk("oor_level", b_level, 1);
    @(negedge clk_i);
    chk("oor_next_data", b_data, 24'h003C00);
    chk("oor_next_busy", b_busy, 1);
    chk("oor_err_once", b_err, 0);
    chk("oor_next_act", b_active, 1);
    @(negedge clk_i);
    chk("oor_next_done", b_done, 1);
    chk("oor_next_idle", b_busy, 0);

    // Reset mid-hold drops everything
    push(1, 8'h99, 20);
    push(2, 8'h01, 1);
    push(3, 8'h02, 1);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_data", data_o, 32'h0000_0000);
    chk("midrst_level", level_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("postrst_level", level_o, 0);
    chk("postrst_busy", busy_o, 0);
    push(0, 8'h5A, 1);
    @(negedge clk_i);
    chk("postrst_load", data_o, 32'h0000_005A);
    repeat (3) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
